// File: rtl/banked_ram_rd_streamer_pkg.sv
// Shared definitions for the banked RAM read streamer.
//   - state_t      : streamer FSM encodings
//   - FIFO_DEPTH   : depth of the output skid FIFO (two entries)
//   - fifo_cnt_t   : FIFO occupancy count type
//   - credit_t     : one bit wider than the occupancy, for credit arithmetic
package banked_ram_rd_streamer_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;
  typedef logic [FIFO_CNT_W:0]   credit_t;

  localparam fifo_cnt_t FIFO_FULL_CNT = fifo_cnt_t'(FIFO_DEPTH);
  localparam credit_t   CREDITS       = credit_t'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/banked_ram_rd_streamer_fifo.sv
// fifo_2deep: two-entry FIFO used as the streamer's output buffer.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   push, din       : write one word (caller must not push a full FIFO
//                     unless it pops in the same cycle)
//   pop, dout       : dout is the head word; pop removes it (ignored if empty)
//   empty, full     : status flags
//   count           : current occupancy (0..2)
module fifo_2deep
  import banked_ram_rd_streamer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output fifo_cnt_t        count
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == FIFO_FULL_CNT);
  assign dout   = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; only the pointers and
  // count define validity, so the RAM array maps onto plain flops/LUT-RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + fifo_cnt_t'(push) - fifo_cnt_t'(do_pop);
    end
  end

endmodule

// File: rtl/banked_ram_rd_streamer.sv
// banked_ram_rd_streamer: reads num_words words from a banked RAM starting at
// base_addr, stepping by stride (mod 2^ADDR_WIDTH), and streams them out on a
// valid/ready interface in request order.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   start, base_addr, stride,
//   num_words                    : transfer launch (sampled when idle)
//   busy, done                   : transfer in progress / one-cycle completion
//   mem_read_req, mem_read_addr,
//   mem_read_data                : RAM read port, data one cycle after request
//   m_valid, m_data, m_ready     : output stream
module banked_ram_rd_streamer
  import banked_ram_rd_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [COUNT_W-1:0]    num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read_req,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, stride_q;
  logic [COUNT_W-1:0]    req_left_q, out_left_q;
  logic                  in_flight_q;
  logic                  done_q, done_d;
  logic                  accept, pop, fifo_push, credit_ok;
  logic                  fifo_empty, fifo_full;
  fifo_cnt_t             fifo_count;
  credit_t               committed;

  assign accept = start && (state_q == ST_IDLE);
  assign pop    = m_valid && m_ready;

  // Words already owed a FIFO slot: what stays buffered after this cycle's pop
  // plus the read whose data arrives this cycle. Counting the pop lets a new
  // request issue every cycle while the stream is flowing.
  assign committed = {1'b0, fifo_count} - credit_t'(pop) + credit_t'(in_flight_q);
  assign credit_ok = (committed < CREDITS);

  // Returning data is always captured; the full guard only matters if the
  // credit rule were ever loosened.
  assign fifo_push = in_flight_q && (!fifo_full || pop);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d      = state_q;
    mem_read_req = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_words == '0) done_d  = 1'b1;
          else                 state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        mem_read_req = credit_ok;
        if (credit_ok && (req_left_q == COUNT_ONE)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && (out_left_q == COUNT_ONE)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Clearing in_flight_q on reset is what discards a read issued just before
  // an abort: its data is never captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      stride_q    <= '0;
      req_left_q  <= '0;
      out_left_q  <= '0;
      in_flight_q <= 1'b0;
    end else begin
      in_flight_q <= mem_read_req;
      if (accept) begin
        addr_q     <= base_addr;
        stride_q   <= stride;
        req_left_q <= num_words;
        out_left_q <= num_words;
      end else begin
        if (mem_read_req) begin
          addr_q     <= addr_q + stride_q;
          req_left_q <= req_left_q - COUNT_ONE;
        end
        if (pop) out_left_q <= out_left_q - COUNT_ONE;
      end
    end
  end

  fifo_2deep #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (fifo_push),
    .pop    (pop),
    .din    (mem_read_data),
    .dout   (m_data),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  assign m_valid       = !fifo_empty;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign mem_read_addr = addr_q;

endmodule

// File: tb/tb_banked_ram_rd_streamer.sv
// Self-checking bench for banked_ram_rd_streamer: table-driven transfers plus
// hand-written sequences for zero-length start, busy start and mid-run reset.
module tb_banked_ram_rd_streamer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [12:0] base_addr;
  logic [12:0] stride;
  logic [15:0] num_words;
  logic        busy;
  logic        done;
  logic        mem_read_req;
  logic [12:0] mem_read_addr;
  logic [15:0] mem_read_data = '0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;

  banked_ram_rd_streamer #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(13),
    .COUNT_W   (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .stride       (stride),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .mem_read_req (mem_read_req),
    .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready)
  );

  always #5 clk = ~clk;

  // RAM contents: a fixed scramble of the address so every word is distinct.
  function automatic logic [15:0] ram_word(input logic [12:0] a);
    return {3'b110, a} ^ 16'h5A5A;
  endfunction

  // RAM model: data appears one cycle after the request and holds.
  always @(posedge clk) begin
    if (mem_read_req) mem_read_data <= ram_word(mem_read_addr);
  end

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Monitor state, cleared at each launch.
  logic [12:0] req_q[$];
  int          req_cyc[$];
  logic [15:0] out_q[$];
  int          out_cyc[$];
  int          done_cnt, done_cyc, max_os, credit_viol;
  bit          done_seen, busy_seen;
  int          start_cyc;

  always @(negedge clk) begin
    int os;
    // Words requested in earlier cycles but not yet taken by the sink.
    os = int'(req_q.size()) - int'(out_q.size());
    if (os > max_os) max_os = os;
    if (os >= 2 && !(m_valid && m_ready) && mem_read_req) credit_viol++;
    if (mem_read_req) begin
      req_q.push_back(mem_read_addr);
      req_cyc.push_back(cycle_cnt);
    end
    if (m_valid && m_ready) begin
      out_q.push_back(m_data);
      out_cyc.push_back(cycle_cnt);
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cycle_cnt;
      done_seen = 1'b1;
    end
    if (busy) busy_seen = 1'b1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    if (i < req_q.size()) return {19'd0, req_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] out_at(input int i);
    if (i < out_q.size()) return {16'd0, out_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int req_cyc_at(input int i);
    if (i < req_cyc.size()) return req_cyc[i];
    return -1;
  endfunction

  function automatic int out_cyc_at(input int i);
    if (i < out_cyc.size()) return out_cyc[i];
    return -1;
  endfunction

  // Call between clock edges; drives a one-cycle start pulse.
  task automatic launch(input logic [12:0] b, input logic [12:0] s, input logic [15:0] n);
    req_q.delete(); req_cyc.delete(); out_q.delete(); out_cyc.delete();
    done_cnt = 0; done_cyc = -1; max_os = 0; credit_viol = 0;
    done_seen = 1'b0; busy_seen = 1'b0;
    base_addr = b; stride = s; num_words = n; start = 1'b1;
    start_cyc = cycle_cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit toggle);
    int cyc = 0;
    while (!done_seen && cyc < 300) begin
      if (toggle) m_ready = ~m_ready;
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b1;
    check({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [12:0] base;
    logic [12:0] stride;
    logic [15:0] num;
    bit          toggle;
    logic [12:0] a0, a1, a2, alast;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{13'h0010, 13'h0001, 16'd4, 1'b0, 13'h0010, 13'h0011, 13'h0012, 13'h0013};
    vecs[1] = '{13'h07FE, 13'h0800, 16'd3, 1'b0, 13'h07FE, 13'h0FFE, 13'h17FE, 13'h17FE};
    vecs[2] = '{13'h1FFF, 13'h0002, 16'd3, 1'b0, 13'h1FFF, 13'h0001, 13'h0003, 13'h0003};
    vecs[3] = '{13'h0020, 13'h0003, 16'd8, 1'b1, 13'h0020, 13'h0023, 13'h0026, 13'h0035};

    reset_n = 1'b0; start = 1'b0; base_addr = '0; stride = '0; num_words = '0; m_ready = 1'b1;
    #2;
    check("rst_busy",  {31'd0, busy},          32'd0);
    check("rst_done",  {31'd0, done},          32'd0);
    check("rst_req",   {31'd0, mem_read_req},  32'd0);
    check("rst_valid", {31'd0, m_valid},       32'd0);
    check("rst_addr",  {19'd0, mem_read_addr}, 32'd0);
    #20;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      launch(vecs[i].base, vecs[i].stride, vecs[i].num);
      wait_done(t, vecs[i].toggle);
      check({t, "_nreq"},  req_q.size(), {16'd0, vecs[i].num});
      check({t, "_nout"},  out_q.size(), {16'd0, vecs[i].num});
      check({t, "_addr0"}, req_at(0), {19'd0, vecs[i].a0});
      check({t, "_addr1"}, req_at(1), {19'd0, vecs[i].a1});
      check({t, "_addr2"}, req_at(2), {19'd0, vecs[i].a2});
      check({t, "_addrN"}, req_at(int'(vecs[i].num) - 1), {19'd0, vecs[i].alast});
      for (int k = 0; k < int'(vecs[i].num); k++) begin
        logic [12:0] ea;
        ea = vecs[i].base + 13'(k) * vecs[i].stride;
        check($sformatf("%s_word%0d", t, k), out_at(k), {16'd0, ram_word(ea)});
      end
      check({t, "_first_req_cycle"}, req_cyc_at(0), start_cyc + 1);
      check({t, "_done_cycle"}, done_cyc, out_cyc_at(int'(vecs[i].num) - 1) + 1);
      check({t, "_done_count"}, done_cnt, 1);
      check({t, "_max_buffered"}, {31'd0, (max_os <= 2)}, 32'd1);
      check({t, "_credit_violations"}, credit_viol, 0);
      check({t, "_busy_after"}, {31'd0, busy}, 32'd0);
      if (!vecs[i].toggle) begin
        check({t, "_req_back_to_back"}, req_cyc_at(int'(vecs[i].num) - 1) - req_cyc_at(0),
              int'(vecs[i].num) - 1);
        check({t, "_out_back_to_back"}, out_cyc_at(int'(vecs[i].num) - 1) - out_cyc_at(0),
              int'(vecs[i].num) - 1);
      end else begin
        // Stalls must actually have exhausted the credits at some point.
        check({t, "_credits_filled"}, max_os, 2);
      end
    end

    // Zero-length transfer: done the next cycle, never busy, no requests.
    launch(13'h0055, 13'h0001, 16'd0);
    repeat (4) @(posedge clk);
    #1;
    check("zero_done_count", done_cnt, 1);
    check("zero_done_cycle", done_cyc, start_cyc + 1);
    check("zero_nreq", req_q.size(), 0);
    check("zero_busy_seen", {31'd0, busy_seen}, 32'd0);

    // Start while busy is ignored; reset after the 2nd word aborts the run.
    launch(13'h0040, 13'h0001, 16'd6);
    base_addr = 13'h0300; num_words = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int cyc = 0;
      while (out_q.size() < 2 && cyc < 50) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("abort_two_words", out_q.size(), 2);
    check("abort_word0", out_at(0), {16'd0, ram_word(13'h0040)});
    check("abort_word1", out_at(1), {16'd0, ram_word(13'h0041)});
    begin
      int n300 = 0;
      foreach (req_q[j]) if (req_q[j] == 13'h0300) n300++;
      check("busy_start_ignored", n300, 0);
    end
    reset_n = 1'b0;
    #1;
    check("abort_busy",  {31'd0, busy},          32'd0);
    check("abort_done",  {31'd0, done},          32'd0);
    check("abort_req",   {31'd0, mem_read_req},  32'd0);
    check("abort_valid", {31'd0, m_valid},       32'd0);
    check("abort_addr",  {19'd0, mem_read_addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    launch(13'h0100, 13'h0001, 16'd2);
    wait_done("post_rst", 1'b0);
    check("post_rst_first_req_cycle", req_cyc_at(0), start_cyc + 1);
    check("post_rst_nreq", req_q.size(), 2);
    check("post_rst_addr0", req_at(0), 32'h100);
    check("post_rst_addr1", req_at(1), 32'h101);
    check("post_rst_nout", out_q.size(), 2);
    check("post_rst_word0", out_at(0), {16'd0, ram_word(13'h0100)});
    check("post_rst_word1", out_at(1), {16'd0, ram_word(13'h0101)});
    check("post_rst_done_count", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
